// File: rtl/pipe_control_unit_pkg.sv
// Shared RV32 instruction definitions and pipeline control bundle.
// Used by pipe_control_unit and ctrl_decode (M_EXT_EN adds mul/div).
package pipe_control_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_PC_IMM = 2'd1,
    WB_MEM    = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic    valid;
    logic    illegal;
    logic    pc_rs1_sel;
    logic    imm_rs2_sel;
    logic    jump_branch_sel;
    logic    md_op;
    logic    md_div;
    logic    mem_wr_en;
    logic    mem_rd_en;
    logic    reg_wr_en;
    wb_sel_e wb_sel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_control_unit_decode.sv
// ID-stage combinational control decoder (ctrl_decode).
// With M_EXT_EN, OP + funct7=0000001 decodes as mul/div, else illegal.
module ctrl_decode
  import pipe_control_unit_pkg::*;
(
  input  logic         id_valid,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output ctrl_bundle_t ctrl
);

  logic unused_bits;
  assign unused_bits = ^funct3[1:0];

  always_comb begin
    ctrl = CTRL_BUBBLE;
    if (id_valid) begin
      ctrl.valid = 1'b1;
      unique case (1'b1)
        (opcode == OPC_OP_IMM),
        (opcode == OPC_LUI): begin
          ctrl.reg_wr_en   = 1'b1;
          ctrl.imm_rs2_sel = 1'b1;
          ctrl.wb_sel      = WB_PC_IMM;
        end
        (opcode == OPC_AUIPC): begin
          ctrl.pc_rs1_sel  = 1'b1;
          ctrl.reg_wr_en   = 1'b1;
          ctrl.imm_rs2_sel = 1'b1;
          ctrl.wb_sel      = WB_PC_IMM;
        end
        (opcode == OPC_OP): begin
`ifdef M_EXT_EN
          ctrl.reg_wr_en = 1'b1;
          if (funct7 == F7_MULDIV) begin
            ctrl.md_op  = 1'b1;
            ctrl.md_div = funct3[2];
          end
`else
          if (funct7 == F7_MULDIV) begin
            ctrl.illegal = 1'b1;
          end else begin
            ctrl.reg_wr_en = 1'b1;
          end
`endif
        end
        (opcode == OPC_LOAD): begin
          ctrl.reg_wr_en   = 1'b1;
          ctrl.imm_rs2_sel = 1'b1;
          ctrl.mem_rd_en   = 1'b1;
          ctrl.wb_sel      = WB_MEM;
        end
        (opcode == OPC_STORE): begin
          ctrl.imm_rs2_sel = 1'b1;
          ctrl.mem_wr_en   = 1'b1;
        end
        (opcode == OPC_BRANCH): begin
          ctrl.pc_rs1_sel      = 1'b1;
          ctrl.imm_rs2_sel     = 1'b1;
          ctrl.jump_branch_sel = 1'b1;
        end
        (opcode == OPC_JAL): begin
          ctrl.pc_rs1_sel      = 1'b1;
          ctrl.reg_wr_en       = 1'b1;
          ctrl.imm_rs2_sel     = 1'b1;
          ctrl.jump_branch_sel = 1'b1;
          ctrl.wb_sel          = WB_PC_IMM;
        end
        (opcode == OPC_JALR): begin
          ctrl.reg_wr_en       = 1'b1;
          ctrl.imm_rs2_sel     = 1'b1;
          ctrl.jump_branch_sel = 1'b1;
          ctrl.wb_sel          = WB_PC_IMM;
        end
        default: begin
          ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// ID/EX -> EX/MEM -> MEM/WB control pipeline with stall, flush, md hold.
// M_EXT_EN enables the multi-cycle mul/div occupancy counter.
module pipe_control_unit
  import pipe_control_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       stall_in,
  input  logic       flush,
  output logic       id_ready,
  output logic       ex_valid,
  output logic       ex_pc_rs1_sel,
  output logic       ex_imm_rs2_sel,
  output logic       ex_jump_branch_sel,
  output logic       ex_md_op,
  output logic       mem_valid,
  output logic       mem_wr_en,
  output logic       mem_rd_en,
  output logic       wb_valid,
  output logic       wb_reg_wr_en,
  output logic [1:0] wb_sel,
  output logic       md_busy,
  output logic       illegal
);

  ctrl_bundle_t dec;
  ctrl_bundle_t id_ex_q;
  ctrl_bundle_t ex_mem_q;
  ctrl_bundle_t mem_wb_q;
  logic         flush_pend_q;
  logic         flush_eff;
  logic         md_busy_w;

  ctrl_decode u_decode (
    .id_valid (id_valid),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .ctrl     (dec)
  );

  assign flush_eff = flush | flush_pend_q;
  assign id_ready  = !stall_in && !md_busy_w;

`ifdef M_EXT_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  logic [3:0] md_cnt_q;

  assign md_busy_w = |md_cnt_q;

  // Loads only when the md op actually enters ID/EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= 4'd0;
    end else if (!stall_in) begin
      if (md_busy_w) begin
        md_cnt_q <= md_cnt_q - 4'd1;
      end else if (!flush_eff && dec.md_op) begin
        md_cnt_q <= dec.md_div ? DIV_LOAD : MUL_LOAD;
      end
    end
  end

  logic unused_cfg;
  assign unused_cfg = 1'b0;
`else
  assign md_busy_w = 1'b0;

  logic [9:0] unused_cfg;
  assign unused_cfg = {5'(MUL_CYCLES), 5'(DIV_CYCLES)};
`endif

  // A flush seen while stalled or busy is held until ID/EX can take it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q      <= CTRL_BUBBLE;
      ex_mem_q     <= CTRL_BUBBLE;
      mem_wb_q     <= CTRL_BUBBLE;
      flush_pend_q <= 1'b0;
    end else if (!stall_in) begin
      mem_wb_q <= ex_mem_q;
      if (md_busy_w) begin
        ex_mem_q     <= CTRL_BUBBLE;
        flush_pend_q <= flush_pend_q | flush;
      end else begin
        ex_mem_q     <= id_ex_q;
        id_ex_q      <= flush_eff ? CTRL_BUBBLE : dec;
        flush_pend_q <= 1'b0;
      end
    end else begin
      flush_pend_q <= flush_pend_q | flush;
    end
  end

  assign ex_valid           = id_ex_q.valid;
  assign ex_pc_rs1_sel      = id_ex_q.pc_rs1_sel;
  assign ex_imm_rs2_sel     = id_ex_q.imm_rs2_sel;
  assign ex_jump_branch_sel = id_ex_q.jump_branch_sel;
  assign ex_md_op           = id_ex_q.md_op;
  assign illegal            = id_ex_q.illegal;

  assign mem_valid = ex_mem_q.valid;
  assign mem_wr_en = ex_mem_q.mem_wr_en;
  assign mem_rd_en = ex_mem_q.mem_rd_en;

  assign wb_valid     = mem_wb_q.valid;
  assign wb_reg_wr_en = mem_wb_q.reg_wr_en;
  assign wb_sel       = mem_wb_q.wb_sel;

  assign md_busy = md_busy_w;

  logic unused_bits;
  assign unused_bits = ^{dec, id_ex_q, ex_mem_q, mem_wb_q, unused_cfg};

endmodule
